dcache_controller: RTL



---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_word_merge.sv | 18 +
 rtl/dcache_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and field positions for the 2-way data cache controller.
// The optional hit/miss counters are enabled with the DCACHE_PERF_CNT_EN macro.
package dcache_pkg;

    localparam int TAG_W      = 23;
    localparam int INDEX_W    = 4;
    localparam int LINE_W     = 256;
    localparam int WORD_W     = 32;
    localparam int SRAM_TAG_W = TAG_W + 2;

    localparam int VALID_BIT  = 24;
    localparam int DIRTY_BIT  = 23;

    // CPU byte address layout: {tag, index, word select, byte offset}
    localparam int WSEL_LSB   = 2;
    localparam int WSEL_W     = 3;
    localparam int INDEX_LSB  = 5;
    localparam int TAG_LSB    = 9;
    localparam int OFFSET_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MISS,
        ST_WRITEBACK,
        ST_READMISS,
        ST_READMISSOK
    } state_e;

endpackage

// File: rtl/dcache_word_merge.sv
// Word extract and word replace on a cache line, selected by the 3-bit word index.
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [WSEL_W-1:0] sel_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_o,
    output logic [LINE_W-1:0] line_o
);

    always_comb begin
        word_o = line_i[sel_i*WORD_W +: WORD_W];
        line_o = line_i;
        line_o[sel_i*WORD_W +: WORD_W] = word_i;
    end

endmodule

// File: rtl/dcache_controller.sv
// CPU-facing write-back / write-allocate controller in front of dcache_sram.
// Optional hit/miss counters are compiled in with DCACHE_PERF_CNT_EN.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [WORD_W-1:0]     cpu_data_i,
    input  logic                  cpu_MemRead_i,
    input  logic                  cpu_MemWrite_i,
    output logic [WORD_W-1:0]     cpu_data_o,
    output logic                  cpu_stall_o,
    input  logic [LINE_W-1:0]     mem_data_i,
    input  logic                  mem_ack_i,
    output logic [LINE_W-1:0]     mem_data_o,
    output logic [31:0]           mem_addr_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [INDEX_W-1:0]    sram_addr_o,
    output logic [SRAM_TAG_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0]     sram_data_o,
    output logic                  sram_enable_o,
    output logic                  sram_write_o,
    input  logic [SRAM_TAG_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0]     sram_data_i,
    input  logic                  sram_hit_i
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    state_e                  state_q, state_d;
    logic [SRAM_TAG_W-1:0]   victim_tag_q, victim_tag_d;
    logic [LINE_W-1:0]       victim_data_q, victim_data_d;
    logic                    mem_enable_q, mem_enable_d;
    logic                    mem_write_q, mem_write_d;
    logic [31:0]             mem_addr_q, mem_addr_d;

    logic                    req, is_write;
    logic [TAG_W-1:0]        addr_tag;
    logic [INDEX_W-1:0]      addr_idx;
    logic [WSEL_W-1:0]       addr_wsel;
    logic [LINE_W-1:0]       merged_line;
    logic                    unused_byte_offset;

    assign req       = cpu_MemRead_i | cpu_MemWrite_i;
    assign is_write  = cpu_MemWrite_i;
    assign addr_tag  = cpu_addr_i[31:TAG_LSB];
    assign addr_idx  = cpu_addr_i[TAG_LSB-1:INDEX_LSB];
    assign addr_wsel = cpu_addr_i[INDEX_LSB-1:WSEL_LSB];
    // Accesses are word-aligned; the byte offset carries no information.
    assign unused_byte_offset = ^cpu_addr_i[WSEL_LSB-1:0];

    dcache_word_merge u_merge (
        .line_i (sram_data_i),
        .sel_i  (addr_wsel),
        .word_i (cpu_data_i),
        .word_o (cpu_data_o),
        .line_o (merged_line)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            victim_tag_q  <= '0;
            victim_data_q <= '0;
            mem_enable_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            victim_tag_q  <= victim_tag_d;
            victim_data_q <= victim_data_d;
            mem_enable_q  <= mem_enable_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        victim_tag_d  = victim_tag_q;
        victim_data_d = victim_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req && !sram_hit_i) begin
                    state_d       = ST_MISS;
                    victim_tag_d  = sram_tag_i;
                    victim_data_d = sram_data_i;
                end
            end
            ST_MISS: begin
                if (victim_tag_q[VALID_BIT] && victim_tag_q[DIRTY_BIT])
                    state_d = ST_WRITEBACK;
                else
                    state_d = ST_READMISS;
            end
            ST_WRITEBACK:  if (mem_ack_i) state_d = ST_READMISS;
            ST_READMISS:   if (mem_ack_i) state_d = ST_READMISSOK;
            ST_READMISSOK: state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase

        // Memory request is registered from the upcoming state, so it drops the cycle after ack.
        mem_enable_d = (state_d == ST_WRITEBACK) || (state_d == ST_READMISS);
        mem_write_d  = (state_d == ST_WRITEBACK);
        case (state_d)
            ST_WRITEBACK: mem_addr_d = {victim_tag_q[TAG_W-1:0], addr_idx, {OFFSET_W{1'b0}}};
            ST_READMISS:  mem_addr_d = {addr_tag, addr_idx, {OFFSET_W{1'b0}}};
            default:      mem_addr_d = mem_addr_q;
        endcase
    end

    always_comb begin
        cpu_stall_o   = (state_q != ST_IDLE) || (req && !sram_hit_i);
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_addr_o   = '0;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    sram_enable_o = 1'b1;
                    sram_addr_o   = addr_idx;
                    sram_tag_o    = {1'b1, 1'b0, addr_tag};
                    if (sram_hit_i && is_write) begin
                        sram_write_o          = 1'b1;
                        sram_tag_o[DIRTY_BIT] = 1'b1;
                        sram_data_o           = merged_line;
                    end
                end
            end
            ST_READMISS: begin
                if (mem_ack_i) begin
                    sram_enable_o = 1'b1;
                    sram_write_o  = 1'b1;
                    sram_addr_o   = addr_idx;
                    sram_tag_o    = {1'b1, 1'b0, addr_tag};
                    sram_data_o   = mem_data_i;
                end
            end
            ST_READMISSOK: begin
                sram_enable_o = 1'b1;
                sram_addr_o   = addr_idx;
                sram_tag_o    = {1'b1, 1'b0, addr_tag};
            end
            default: ;
        endcase
        if (rst_i) begin
            sram_enable_o = 1'b0;
            sram_write_o  = 1'b0;
            sram_addr_o   = '0;
            sram_tag_o    = '0;
            sram_data_o   = '0;
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = victim_data_q;

`ifdef DCACHE_PERF_CNT_EN
    logic        refill_done_q;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // The first IDLE cycle after a refill is the re-served miss, not a new hit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            refill_done_q <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            refill_done_q <= (state_q == ST_READMISSOK);
            if (state_q == ST_IDLE && req && sram_hit_i && !refill_done_q)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == ST_IDLE && req && !sram_hit_i)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
